// File: rtl/sma_moving_stats.sv
// sma_moving_stats: per-stock moving-window sum and mean, two-stage pipeline, one sample per cycle.
module sma_moving_stats #(
    parameter int NUM_STOCKS  = 4,
    parameter int BUFFER_SIZE = 64,
    parameter int DATA_WIDTH  = 32,
    localparam int SID_W  = $clog2(NUM_STOCKS),
    localparam int LOG_BS = $clog2(BUFFER_SIZE),
    localparam int SUM_W  = DATA_WIDTH + LOG_BS
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [SID_W-1:0]      i_stock_id,
    input  logic [DATA_WIDTH-1:0] i_incoming_price,
    input  logic [DATA_WIDTH-1:0] i_outgoing_price,
    output logic                  o_valid,
    output logic [SID_W-1:0]      o_stock_id,
    output logic [SUM_W-1:0]      o_sum,
    output logic [DATA_WIDTH-1:0] o_mean,
    output logic                  o_full
);
    localparam logic [LOG_BS:0] FULL_CNT = (LOG_BS+1)'(BUFFER_SIZE);
    localparam logic [LOG_BS:0] ONE_CNT  = (LOG_BS+1)'(1);
    logic [SUM_W-1:0]      sum [NUM_STOCKS];
    logic [LOG_BS:0]       cnt [NUM_STOCKS];
    logic                  s1_valid;
    logic [SID_W-1:0]      s1_id;
    logic [DATA_WIDTH-1:0] s1_price;
    logic                  was_full;
    logic                  new_full;
    logic [DATA_WIDTH-1:0] out_eff;
    logic [SUM_W-1:0]      new_sum;
    logic [LOG_BS:0]       new_cnt;
    // Until the window is full the outgoing slot holds stale data and must not be subtracted.
    always_comb begin
        was_full = cnt[s1_id] == FULL_CNT;
        out_eff  = was_full ? i_outgoing_price : '0;
        new_sum  = sum[s1_id] + SUM_W'(s1_price) - SUM_W'(out_eff);
        new_cnt  = was_full ? cnt[s1_id] : cnt[s1_id] + ONE_CNT;
        new_full = new_cnt == FULL_CNT;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid   <= 1'b0;
            s1_id      <= '0;
            s1_price   <= '0;
            o_valid    <= 1'b0;
            o_stock_id <= '0;
            o_sum      <= '0;
            o_mean     <= '0;
            o_full     <= 1'b0;
            for (int i = 0; i < NUM_STOCKS; i++) begin
                sum[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            s1_valid <= i_valid && (32'(i_stock_id) < NUM_STOCKS);
            s1_id    <= i_stock_id;
            s1_price <= i_incoming_price;
            o_valid  <= s1_valid;
            if (s1_valid) begin
                sum[s1_id] <= new_sum;
                cnt[s1_id] <= new_cnt;
                o_stock_id <= s1_id;
                o_sum      <= new_sum;
                o_full     <= new_full;
                o_mean     <= new_full ? DATA_WIDTH'(new_sum >> LOG_BS) : '0;
            end
        end
    end
endmodule

// File: tb/tb_sma_moving_stats.sv
// tb_sma_moving_stats: directed checks of the moving-stats pipeline on three parameterisations.
module tb_sma_moving_stats;
    logic        i_clk = 1'b0;
    logic        i_reset, i_valid;
    logic [1:0]  i_stock_id;
    logic [31:0] i_incoming_price, i_outgoing_price;
    logic        a_valid, b_valid, c_valid, a_full, b_full, c_full;
    logic [1:0]  a_id, b_id, c_id;
    logic [33:0] a_sum, b_sum;
    logic [9:0]  c_sum;
    logic [31:0] a_mean, b_mean;
    logic [7:0]  c_mean;
    int errors = 0, checks = 0, sel = 0;

    always #5 i_clk = ~i_clk;

    sma_moving_stats #(.NUM_STOCKS(4), .BUFFER_SIZE(4), .DATA_WIDTH(32)) u_a (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_stock_id(i_stock_id),
        .i_incoming_price(i_incoming_price), .i_outgoing_price(i_outgoing_price),
        .o_valid(a_valid), .o_stock_id(a_id), .o_sum(a_sum), .o_mean(a_mean), .o_full(a_full));
    sma_moving_stats #(.NUM_STOCKS(3), .BUFFER_SIZE(4), .DATA_WIDTH(32)) u_b (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_stock_id(i_stock_id),
        .i_incoming_price(i_incoming_price), .i_outgoing_price(i_outgoing_price),
        .o_valid(b_valid), .o_stock_id(b_id), .o_sum(b_sum), .o_mean(b_mean), .o_full(b_full));
    sma_moving_stats #(.NUM_STOCKS(4), .BUFFER_SIZE(4), .DATA_WIDTH(8)) u_c (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_stock_id(i_stock_id),
        .i_incoming_price(i_incoming_price[7:0]), .i_outgoing_price(i_outgoing_price[7:0]),
        .o_valid(c_valid), .o_stock_id(c_id), .o_sum(c_sum), .o_mean(c_mean), .o_full(c_full));

    typedef struct {
        logic        v;
        logic [1:0]  id;
        logic [31:0] p;
        logic [31:0] o;
        logic        ev;
        logic [1:0]  eid;
        logic [33:0] esum;
        logic [31:0] emean;
        logic        efull;
    } vec_t;
    vec_t tbl [13];

    task automatic drive(input logic v, input logic [1:0] id, input logic [31:0] p, input logic [31:0] o);
        i_valid = v;
        i_stock_id = id;
        i_incoming_price = p;
        i_outgoing_price = o;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        i_reset = 1'b0;
    endtask

    task automatic chk(input string name, input logic ev, input logic [1:0] eid, input logic [33:0] es,
                       input logic [31:0] em, input logic ef);
        logic        av, af;
        logic [1:0]  aid;
        logic [33:0] as;
        logic [31:0] am;
        av  = sel == 0 ? a_valid : sel == 1 ? b_valid : c_valid;
        aid = sel == 0 ? a_id : sel == 1 ? b_id : c_id;
        as  = sel == 0 ? a_sum : sel == 1 ? b_sum : {24'd0, c_sum};
        am  = sel == 0 ? a_mean : sel == 1 ? b_mean : {24'd0, c_mean};
        af  = sel == 0 ? a_full : sel == 1 ? b_full : c_full;
        checks++;
        if ({av, aid, as, am, af} !== {ev, eid, es, em, ef}) begin
            errors++;
            $display("FAIL %s: got v=%0d id=%0d sum=%0d mean=%0d full=%0d, want v=%0d id=%0d sum=%0d mean=%0d full=%0d",
                     name, av, aid, as, am, af, ev, eid, es, em, ef);
        end
    endtask

    initial begin
        // Row k: inputs for this cycle; expected outputs after this cycle's edge (result of row k-1).
        tbl[0]  = '{1'b1, 2'd0, 32'd10, 32'd0,          1'b0, 2'd0, 34'd0,   32'd0,  1'b0};
        tbl[1]  = '{1'b1, 2'd0, 32'd20, 32'hFFFF_FFFF, 1'b1, 2'd0, 34'd10,  32'd0,  1'b0};
        tbl[2]  = '{1'b1, 2'd0, 32'd30, 32'hFFFF_FFFF, 1'b1, 2'd0, 34'd30,  32'd0,  1'b0};
        tbl[3]  = '{1'b1, 2'd0, 32'd40, 32'hFFFF_FFFF, 1'b1, 2'd0, 34'd60,  32'd0,  1'b0};
        tbl[4]  = '{1'b1, 2'd0, 32'd50, 32'hFFFF_FFFF, 1'b1, 2'd0, 34'd100, 32'd25, 1'b1};
        tbl[5]  = '{1'b0, 2'd0, 32'd0,  32'd10,        1'b1, 2'd0, 34'd140, 32'd35, 1'b1};
        tbl[6]  = '{1'b1, 2'd1, 32'd7,  32'd0,         1'b0, 2'd0, 34'd140, 32'd35, 1'b1};
        tbl[7]  = '{1'b1, 2'd2, 32'd9,  32'd0,         1'b1, 2'd1, 34'd7,   32'd0,  1'b0};
        tbl[8]  = '{1'b1, 2'd1, 32'd3,  32'd0,         1'b1, 2'd2, 34'd9,   32'd0,  1'b0};
        tbl[9]  = '{1'b0, 2'd0, 32'd0,  32'd0,         1'b1, 2'd1, 34'd10,  32'd0,  1'b0};
        tbl[10] = '{1'b1, 2'd0, 32'd60, 32'd0,         1'b0, 2'd1, 34'd10,  32'd0,  1'b0};
        tbl[11] = '{1'b0, 2'd0, 32'd0,  32'd20,        1'b1, 2'd0, 34'd180, 32'd45, 1'b1};
        tbl[12] = '{1'b0, 2'd0, 32'd0,  32'd0,         1'b0, 2'd0, 34'd180, 32'd45, 1'b1};

        i_reset = 1'b1;
        drive(1'b1, 2'd0, 32'd77, 32'd0);
        drive(1'b1, 2'd0, 32'd77, 32'd0);
        i_reset = 1'b0;
        chk("reset_state", 1'b0, 2'd0, 34'd0, 32'd0, 1'b0);
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        chk("valid_in_reset", 1'b0, 2'd0, 34'd0, 32'd0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].id, tbl[i].p, tbl[i].o);
            chk($sformatf("row%0d", i), tbl[i].ev, tbl[i].eid, tbl[i].esum, tbl[i].emean, tbl[i].efull);
        end

        drive(1'b1, 2'd3, 32'd99, 32'd0);
        chk("inflight_s1", 1'b0, 2'd0, 34'd180, 32'd45, 1'b1);
        i_reset = 1'b1;
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        i_reset = 1'b0;
        chk("reset_mid", 1'b0, 2'd0, 34'd0, 32'd0, 1'b0);
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        chk("no_late_valid", 1'b0, 2'd0, 34'd0, 32'd0, 1'b0);
        drive(1'b1, 2'd3, 32'd5, 32'd0);
        drive(1'b0, 2'd0, 32'd0, 32'hFFFF_FFFF);
        chk("after_reset", 1'b1, 2'd3, 34'd5, 32'd0, 1'b0);
        drive(1'b1, 2'd0, 32'd1, 32'd0);
        drive(1'b0, 2'd0, 32'd0, 32'hFFFF_FFFF);
        chk("stock0_cleared", 1'b1, 2'd0, 34'd1, 32'd0, 1'b0);

        sel = 1;
        do_reset();
        drive(1'b1, 2'd2, 32'd8, 32'd0);
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        chk("ill_pre", 1'b1, 2'd2, 34'd8, 32'd0, 1'b0);
        drive(1'b1, 2'd3, 32'd100, 32'd0);
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        chk("ill_novalid", 1'b0, 2'd2, 34'd8, 32'd0, 1'b0);
        drive(1'b1, 2'd2, 32'd1, 32'd0);
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        chk("ill_s2", 1'b1, 2'd2, 34'd9, 32'd0, 1'b0);
        drive(1'b1, 2'd0, 32'd4, 32'd0);
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        chk("ill_s0", 1'b1, 2'd0, 34'd4, 32'd0, 1'b0);

        sel = 2;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'd0, 32'd255, 32'hFFFF_FFFF);
            drive(1'b0, 2'd0, 32'd0, 32'hFFFF_FFFF);
            chk($sformatf("wrap_fill%0d", k), 1'b1, 2'd0, 34'(255 * (k + 1)),
                k == 3 ? 32'd255 : 32'd0, k == 3);
        end
        drive(1'b1, 2'd0, 32'd0, 32'd0);
        drive(1'b0, 2'd0, 32'd0, 32'd255);
        chk("wrap_steady", 1'b1, 2'd0, 34'd765, 32'd191, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
